uart_rx_fifo: RTL and testbench

//  Receive-side buffer placed directly downstream of the UART receiver. Captures each

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_fifo_ram.sv | 24 ++
 rtl/uart_rx_fifo.sv | 95 +++++++++
 tb/tb_uart_rx_fifo.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants used by the TX/RX blocks and the receive FIFO.
package uart_pkg;
  localparam int UART_DATA_W  = 8;
  localparam int PARITY_CNT_W = 8;
  localparam logic [PARITY_CNT_W-1:0] PARITY_CNT_MAX = 8'hFF;
endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x UART_DATA_W storage: one synchronous write port, one asynchronous read port.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [UART_DATA_W-1:0] rdata
);

  logic [UART_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer behind the UART receiver, with a sticky overflow flag
// and a saturating parity-error counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [UART_DATA_W-1:0]  rx_byte,
  input  logic                    rx_valid,
  input  logic                    rx_parity_err,
  output logic [UART_DATA_W-1:0]  rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [ADDR_W:0]         count,
  output logic                    full,
  output logic                    almost_full,
  output logic                    overflow,
  output logic [PARITY_CNT_W-1:0] parity_cnt,
  input  logic                    clear_errors
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LEVEL);

  function automatic logic [PARITY_CNT_W-1:0] sat_inc(input logic [PARITY_CNT_W-1:0] v);
    return (v == PARITY_CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [ADDR_W-1:0]      wr_ptr;
  logic [ADDR_W-1:0]      rd_ptr;
  logic [UART_DATA_W-1:0] ram_rdata;
  logic                   good_byte;
  logic                   push;
  logic                   pop;
  logic                   overflow_evt;

  // Flags decode only the registered count, so no input reaches them combinationally.
  assign rd_valid    = (count != '0);
  assign full        = (count == DEPTH_CNT);
  assign almost_full = (count >= AFULL_CNT);

  assign good_byte    = rx_valid & ~rx_parity_err;
  assign pop          = rd_valid & rd_ready;
  assign push         = good_byte & (~full | pop);
  assign overflow_evt = good_byte & full & ~pop;

  assign rd_data = rd_valid ? ram_rdata : '0;

  uart_fifo_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (rx_byte),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A new error event in the same cycle as clear_errors takes priority over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      parity_cnt <= '0;
    end else begin
      if (overflow_evt)      overflow <= 1'b1;
      else if (clear_errors) overflow <= 1'b0;

      if (rx_parity_err)     parity_cnt <= clear_errors ? PARITY_CNT_W'(1) : sat_inc(parity_cnt);
      else if (clear_errors) parity_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: accepted bytes are queued as they are driven
// and compared when the host pops them.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_byte = '0;
  logic       rx_valid = 1'b0;
  logic       rx_parity_err = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [4:0] count;
  logic       full;
  logic       almost_full;
  logic       overflow;
  logic [7:0] parity_cnt;
  logic       clear_errors = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [7:0] sb_q[$];
  int         m_count = 0;
  logic       m_ovf = 1'b0;
  int         m_pc = 0;

  uart_rx_fifo dut (
    .clk           (clk),
    .reset         (reset),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .rx_parity_err (rx_parity_err),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .count         (count),
    .full          (full),
    .almost_full   (almost_full),
    .overflow      (overflow),
    .parity_cnt    (parity_cnt),
    .clear_errors  (clear_errors)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check the current state against the model,
  // then advance the model by the effect of this cycle's inputs.
  task automatic step(input logic [7:0] b, input logic v, input logic pe,
                      input logic rdy, input logic clr);
    logic       exp_pop;
    logic       exp_push;
    logic [7:0] exp_b;
    @(negedge clk);
    rx_byte = b; rx_valid = v; rx_parity_err = pe; rd_ready = rdy; clear_errors = clr;
    #1;
    check("count", count, m_count);
    check("rd_valid", rd_valid, m_count != 0);
    check("full", full, m_count == 16);
    check("almost_full", almost_full, m_count >= 12);
    check("overflow", overflow, m_ovf);
    check("parity_cnt", parity_cnt, m_pc);
    exp_pop = (m_count != 0) && rdy;
    if (m_count == 0) check("rd_data_empty", rd_data, 8'h00);
    else check("rd_data_head", rd_data, sb_q[0]);
    if (exp_pop) begin
      exp_b = sb_q.pop_front();
      check("rd_data_pop", rd_data, exp_b);
    end
    exp_push = v && !pe && ((m_count < 16) || exp_pop);
    if (exp_push) sb_q.push_back(b);
    m_count = m_count + (exp_push ? 1 : 0) - (exp_pop ? 1 : 0);
    if (v && !pe && !exp_push) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (pe) m_pc = clr ? 1 : ((m_pc == 255) ? 255 : m_pc + 1);
    else if (clr) m_pc = 0;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rx_valid = 1'b0; rx_parity_err = 1'b0; rd_ready = 1'b0; clear_errors = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    m_count = 0; m_ovf = 1'b0; m_pc = 0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    // Test 1: single byte through
    do_reset();
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("t1_valid", rd_valid, 1'b1);
    check("t1_data", rd_data, 8'hA5);
    check("t1_count", count, 5'd1);
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("t1_empty_valid", rd_valid, 1'b0);
    check("t1_empty_data", rd_data, 8'h00);

    // Test 2: fill, overflow, drain in order
    for (int i = 0; i < 16; i++) step(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("t2_overflow", overflow, 1'b1);
    check("t2_count", count, 5'd16);
    check("t2_full", full, 1'b1);
    drain(17);
    #1;
    check("t2_drained", count, 5'd0);

    // Test 3: push and pop together while full
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(8'(8'h20 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    check("t3_count", count, 5'd16);
    check("t3_overflow", overflow, 1'b0);
    drain(17);

    // Test 4: pointer wrap with random interleaving
    for (int i = 0; i < 40; i++)
      step(8'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b0);
    drain(18);

    // Test 5: parity counter saturation and clear priority
    for (int i = 0; i < 300; i++)
      step(8'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
    #1;
    check("t5_sat", parity_cnt, 8'hFF);
    check("t5_none_stored", count, 5'd0);
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    check("t5_clear_wins", parity_cnt, 8'h01);

    // Test 6: reset with queued bytes and a set overflow flag
    for (int i = 0; i < 17; i++) step(8'(8'h60 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    drain(12);
    do_reset();
    #1;
    check("t6_count", count, 5'd0);
    check("t6_valid", rd_valid, 1'b0);
    check("t6_overflow", overflow, 1'b0);
    check("t6_parity", parity_cnt, 8'h00);
    step(8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
